// File: rtl/uart_tx.sv
// UART transmitter: one start bit, n_bits data bits sent LSB first, an optional parity bit, then
// stop_bits stop bits. A single FSM drives every output straight from a flop.
module uart_tx #(
  parameter int unsigned clock_rate  = 100000000,
  parameter int unsigned baud_rate   = 250000,
  parameter int unsigned n_bits      = 8,
  parameter int unsigned parity_mode = 0,
  parameter int unsigned stop_bits   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [n_bits-1:0] data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BitCycles = clock_rate / baud_rate;
  localparam int unsigned CntW      = (BitCycles > 1) ? $clog2(BitCycles) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(BitCycles - 1);
  localparam logic [3:0]      BitLast  = 4'(n_bits - 1);
  localparam logic [3:0]      StopLast = 4'(stop_bits - 1);
  localparam logic            HasParity = (parity_mode != 0);
  localparam logic            OddParity = (parity_mode == 2);

  if (BitCycles < 2) begin : gen_bad_rate
    $error("uart_tx: clock_rate / baud_rate must be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [3:0]        idx_q;
  logic [n_bits-1:0] shift_q;
  logic              parity_q;

  wire bit_end = (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx         <= 1'b1;
      data_ready <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (data_valid && data_ready) begin
            shift_q    <= data;
            // Parity is fixed at accept so later shifting cannot disturb it.
            parity_q   <= (^data) ^ OddParity;
            state_q    <= StStart;
            cnt_q      <= '0;
            idx_q      <= '0;
            tx         <= 1'b0;
            data_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end
        StStart: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= StData;
            tx      <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == BitLast) begin
              idx_q <= '0;
              if (HasParity) begin
                state_q <= StParity;
                tx      <= parity_q;
              end else begin
                state_q <= StStop;
                tx      <= 1'b1;
              end
            end else begin
              idx_q   <= idx_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx      <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StParity: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= StStop;
            tx      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            cnt_q <= '0;
            // idx_q doubles as the stop-bit counter.
            if (idx_q == StopLast) begin
              idx_q      <= '0;
              state_q    <= StIdle;
              data_ready <= 1'b1;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four parameterisations, each frame compared cycle by cycle
// against a line model built from the frame format rules.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [3:0] tx_w, busy_w, ready_w, done_w;
  logic [3:0] valid_r = '0;
  logic [7:0] data8 [3];
  logic [4:0] data5 = '0;

  int checks = 0;
  int errors = 0;

  // Instance configs: 0 default, 1 even parity, 2 odd parity, 3 small/fast.
  int bc_p  [4] = '{400, 400, 400, 4};
  int nb_p  [4] = '{8, 8, 8, 5};
  int par_p [4] = '{0, 1, 2, 0};
  int sb_p  [4] = '{1, 1, 1, 2};

  typedef struct packed {
    logic tx;
    logic busy;
    logic ready;
    logic done;
  } samp_t;

  samp_t obs[$];

  uart_tx u_def (
    .clk(clk), .rst(rst), .data(data8[0]), .data_valid(valid_r[0]), .data_ready(ready_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0])
  );

  uart_tx #(.parity_mode(1)) u_even (
    .clk(clk), .rst(rst), .data(data8[1]), .data_valid(valid_r[1]), .data_ready(ready_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1])
  );

  uart_tx #(.parity_mode(2)) u_odd (
    .clk(clk), .rst(rst), .data(data8[2]), .data_valid(valid_r[2]), .data_ready(ready_w[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2])
  );

  uart_tx #(.clock_rate(16), .baud_rate(4), .n_bits(5), .stop_bits(2)) u_small (
    .clk(clk), .rst(rst), .data(data5), .data_valid(valid_r[3]), .data_ready(ready_w[3]),
    .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(done_w[3])
  );

  function automatic int frame_len(int inst);
    return (1 + nb_p[inst] + ((par_p[inst] != 0) ? 1 : 0) + sb_p[inst]) * bc_p[inst];
  endfunction

  // Line level during bit slot 'slot' of a frame carrying 'word'.
  function automatic logic line_bit(int inst, logic [7:0] word, int slot);
    if (slot == 0) return 1'b0;
    if (slot <= nb_p[inst]) return word[slot-1];
    if (par_p[inst] != 0 && slot == nb_p[inst] + 1)
      return (($countones(word) % 2) == 1) ^ (par_p[inst] == 2);
    return 1'b1;
  endfunction

  // Expected outputs j cycles after the accept edge.
  function automatic samp_t expect_samp(int inst, logic [7:0] word, int j);
    samp_t s;
    int    len;
    len = frame_len(inst);
    if (j < len) s = '{tx: line_bit(inst, word, j / bc_p[inst]), busy: 1'b1, ready: 1'b0,
                       done: 1'b0};
    else         s = '{tx: 1'b1, busy: 1'b0, ready: 1'b1, done: (j == len)};
    return s;
  endfunction

  task automatic set_data(int inst, logic [7:0] w);
    if (inst == 3) data5 = w[4:0];
    else           data8[inst] = w;
  endtask

  task automatic send(int inst, logic [7:0] w, bit hold);
    @(negedge clk);
    set_data(inst, w);
    valid_r[inst] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) valid_r[inst] = 1'b0;
  endtask

  // Samples outputs on ncyc falling edges; optionally pulses or drops data_valid on the way.
  task automatic capture(int inst, int ncyc, int pulse_at, int drop_at, logic [7:0] pw);
    obs.delete();
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      obs.push_back({tx_w[inst], busy_w[inst], ready_w[inst], done_w[inst]});
      if (j == pulse_at) begin
        set_data(inst, pw);
        valid_r[inst] = 1'b1;
      end
      if (j == drop_at) valid_r[inst] = 1'b0;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) data8[i] = '0;
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({tx_w[i], busy_w[i], ready_w[i], done_w[i]} !== 4'b1010) begin
        errors++;
        $display("FAIL reset_async inst %0d: tx/busy/ready/done=%b, expected 1010", i,
                 {tx_w[i], busy_w[i], ready_w[i], done_w[i]});
      end
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({tx_w[i], busy_w[i], ready_w[i], done_w[i]} !== 4'b1010) begin
        errors++;
        $display("FAIL idle_after_reset inst %0d: tx/busy/ready/done=%b, expected 1010", i,
                 {tx_w[i], busy_w[i], ready_w[i], done_w[i]});
      end
    end
  endtask

  task automatic test_default_0x55;
    samp_t want;
    int    first_done;
    send(0, 8'h55, 1'b0);
    capture(0, 4002, -1, -1, 8'h00);
    checks++;
    for (int j = 0; j < obs.size(); j++) begin
      want = expect_samp(0, 8'h55, j);
      if (obs[j] !== want) begin
        errors++;
        $display("FAIL frame_0x55 cycle %0d: tx/busy/ready/done=%b, expected %b", j, obs[j], want);
        break;
      end
    end
    first_done = -1;
    for (int j = 0; j < obs.size(); j++) if (obs[j].done === 1'b1 && first_done < 0) first_done = j;
    checks++;
    if (first_done !== 4000) begin
      errors++;
      $display("FAIL done_cycle_0x55: frame_done at %0d, expected 4000", first_done);
    end
    checks++;
    if ({obs[0].tx, obs[399].tx, obs[400].tx, obs[800].tx, obs[3600].tx} !== 5'b00101) begin
      errors++;
      $display("FAIL bits_0x55: start/start/b0/b1/stop=%b, expected 00101",
               {obs[0].tx, obs[399].tx, obs[400].tx, obs[800].tx, obs[3600].tx});
    end
  endtask

  task automatic test_parity;
    samp_t want;
    for (int inst = 1; inst <= 2; inst++) begin
      send(inst, 8'h07, 1'b0);
      capture(inst, 4402, -1, -1, 8'h00);
      checks++;
      for (int j = 0; j < obs.size(); j++) begin
        want = expect_samp(inst, 8'h07, j);
        if (obs[j] !== want) begin
          errors++;
          $display("FAIL parity_frame inst %0d cycle %0d: tx/busy/ready/done=%b, expected %b",
                   inst, j, obs[j], want);
          break;
        end
      end
      checks++;
      if (obs[3600].tx !== ((inst == 1) ? 1'b1 : 1'b0) || obs[4400].done !== 1'b1) begin
        errors++;
        $display("FAIL parity_bit inst %0d: parity=%b done@4400=%b, expected parity %0d done 1",
                 inst, obs[3600].tx, obs[4400].done, (inst == 1) ? 1 : 0);
      end
    end
  endtask

  task automatic test_random_default;
    samp_t      want;
    logic [7:0] w;
    for (int k = 0; k < 2; k++) begin
      w = 8'($urandom);
      send(0, w, 1'b0);
      capture(0, 4002, -1, -1, 8'h00);
      checks++;
      for (int j = 0; j < obs.size(); j++) begin
        want = expect_samp(0, w, j);
        if (obs[j] !== want) begin
          errors++;
          $display("FAIL random_frame word %h cycle %0d: tx/busy/ready/done=%b, expected %b",
                   w, j, obs[j], want);
          break;
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    samp_t want;
    int    len;
    len = frame_len(0);
    send(0, 8'hA5, 1'b1);
    set_data(0, 8'h3C);
    capture(0, 2 * len + 2, -1, len + 5, 8'h00);
    checks++;
    for (int j = 0; j < obs.size(); j++) begin
      want = (j <= len) ? expect_samp(0, 8'hA5, j) : expect_samp(0, 8'h3C, j - len - 1);
      if (obs[j] !== want) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: tx/busy/ready/done=%b, expected %b", j, obs[j],
                 want);
        break;
      end
    end
    checks++;
    if ({obs[len].done, obs[len + 1].tx, obs[len + 1].busy} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_gap: done/tx/busy around boundary=%b, expected 101",
               {obs[len].done, obs[len + 1].tx, obs[len + 1].busy});
    end
  endtask

  task automatic test_ignore_busy;
    samp_t      want;
    logic [7:0] w;
    w = 8'($urandom_range(0, 254));
    send(0, w, 1'b0);
    capture(0, 4002, 1400, 1401, 8'hFF);
    checks++;
    for (int j = 0; j < obs.size(); j++) begin
      want = expect_samp(0, w, j);
      if (obs[j] !== want) begin
        errors++;
        $display("FAIL ignore_valid word %h cycle %0d: tx/busy/ready/done=%b, expected %b",
                 w, j, obs[j], want);
        break;
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    samp_t want;
    send(0, 8'($urandom), 1'b0);
    repeat (4 * 400 + 200) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({tx_w[0], busy_w[0], ready_w[0], done_w[0]} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_mid_frame: tx/busy/ready/done=%b, expected 1010",
               {tx_w[0], busy_w[0], ready_w[0], done_w[0]});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    capture(0, 20, -1, -1, 8'h00);
    checks++;
    for (int j = 0; j < obs.size(); j++) begin
      if (obs[j] !== 4'b1010) begin
        errors++;
        $display("FAIL post_reset_idle cycle %0d: tx/busy/ready/done=%b, expected 1010", j,
                 obs[j]);
        break;
      end
    end
    send(0, 8'h81, 1'b0);
    capture(0, 4002, -1, -1, 8'h00);
    checks++;
    for (int j = 0; j < obs.size(); j++) begin
      want = expect_samp(0, 8'h81, j);
      if (obs[j] !== want) begin
        errors++;
        $display("FAIL frame_0x81 cycle %0d: tx/busy/ready/done=%b, expected %b", j, obs[j],
                 want);
        break;
      end
    end
  endtask

  task automatic test_small_config;
    samp_t      want;
    logic [7:0] w;
    for (int k = 0; k < 20; k++) begin
      w = 8'($urandom) & 8'h1F;
      send(3, w, 1'b0);
      capture(3, 34, -1, -1, 8'h00);
      checks++;
      for (int j = 0; j < obs.size(); j++) begin
        want = expect_samp(3, w, j);
        if (obs[j] !== want) begin
          errors++;
          $display("FAIL small_frame word %h cycle %0d: tx/busy/ready/done=%b, expected %b",
                   w, j, obs[j], want);
          break;
        end
      end
      checks++;
      if (obs[32].done !== 1'b1) begin
        errors++;
        $display("FAIL small_len word %h: frame_done at cycle 32=%b, expected 1", w, obs[32].done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_0x55();
    test_parity();
    test_random_default();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    test_small_config();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL expose parameter clock_rate, default 100000000, giving the clk frequency in Hz.
REQ-002 The block SHALL expose parameter baud_rate, default 250000, giving the serial bit rate in bit/s.
REQ-003 The block SHALL expose parameter n_bits, default 8, range 5..9, giving data bits per frame.
REQ-004 The block SHALL expose parameter parity_mode, default 0, meaning 0 = none, 1 = even, 2 = odd.
REQ-005 The block SHALL expose parameter stop_bits, default 1, range 1..2, giving stop bits per frame.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-007 clk  input  1  rising-edge system clock.
REQ-008 rst  input  1  asynchronous active-low reset.
REQ-009 data  input  n_bits  parallel word to send; sampled only on accept.
REQ-010 data_valid  input  1  request to send data.
REQ-011 data_ready  output  1  high when a word can be accepted.
REQ-012 tx  output  1  serial line; idle high.
REQ-013 busy  output  1  high while a frame is on the line.
REQ-014 frame_done  output  1  one-cycle pulse at end of each frame.

Function
REQ-015 Bit period SHALL be bit_cycles = clock_rate / baud_rate (integer division); elaboration SHALL fail if bit_cycles < 2.
REQ-016 The bit-period counter SHALL be $clog2(bit_cycles) bits wide, count 0..bit_cycles-1, and wrap to 0 at each bit boundary.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when parity_mode = 0.
REQ-018 Accept SHALL occur on a rising clk edge with data_valid = 1 and data_ready = 1; data SHALL be latched into a shift register at that edge.
REQ-019 data_ready SHALL be 1 only in IDLE; data_valid while not ready SHALL be ignored, with no queuing.
REQ-020 On accept, the FSM SHALL enter START at the same edge; tx SHALL be 0 from the cycle after accept for exactly bit_cycles cycles.
REQ-021 In DATA, the block SHALL send n_bits bits LSB first, each held for bit_cycles cycles; the bit index counter SHALL run 0..n_bits-1.
REQ-022 In PARITY, tx SHALL equal the XOR of the latched bits for even parity, or its inverse for odd parity, held for bit_cycles cycles.
REQ-023 In STOP, tx SHALL be 1 for stop_bits*bit_cycles cycles.
REQ-024 Frame length from the first start-bit cycle to the return to IDLE SHALL be (1 + n_bits + (parity_mode != 0) + stop_bits) * bit_cycles cycles exactly.
REQ-025 frame_done SHALL pulse high for one cycle in the first IDLE cycle after STOP; data_ready SHALL rise in that same cycle.
REQ-026 Back-to-back: an accept in the frame_done cycle SHALL start the next start bit the following cycle, with no extra idle bit.
REQ-027 busy SHALL be 1 in START, DATA, PARITY, STOP and 0 in IDLE.
REQ-028 tx, data_ready, busy and frame_done SHALL be driven directly from flip-flops (no combinational path from inputs).
REQ-029 Changes on data after accept SHALL NOT affect the frame in flight.

Reset
REQ-030 While rst = 0, the block SHALL immediately force tx = 1, data_ready = 1, busy = 0, frame_done = 0, state IDLE, and all counters and the shift register to 0, regardless of clk.
REQ-031 Reset mid-frame SHALL abort the frame with no frame_done; the first accept after rst deasserts SHALL start a complete fresh frame.

Verification
REQ-032 Defaults (bit_cycles = 400); accept data = 0x55 -> tx low 400 cycles, then 1,0,1,0,1,0,1,0 at 400 cycles each, then high 400 cycles; frame_done at cycle 4000 after accept+1.
REQ-033 parity_mode = 1, data = 0x07 -> parity bit 1; parity_mode = 2, same data -> parity bit 0; frame length 4400 cycles.
REQ-034 data_valid held high continuously with 0xA5 then 0x3C -> second start bit begins the cycle after frame_done; 20 bit periods total with no idle gap.
REQ-035 data_valid pulsed during DATA with 0xFF -> ignored; line shows only the original word; data_ready stays 0 until frame_done.
REQ-036 rst asserted during bit 3 of DATA -> tx = 1 within the same cycle, busy = 0, no frame_done; new accept of 0x81 -> full correct frame.
REQ-037 clock_rate = 16, baud_rate = 4, n_bits = 5, stop_bits = 2 -> 4-cycle bits; frame of 32 cycles; counter wraps correctly at each bit boundary.
